// File: rtl/seg_scan_decoder.sv
// Scanned seven-segment bus receiver: waits for each digit strobe to settle, decodes the
// active-low cathode pattern to a hex nibble and holds one nibble per anode position.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_DIGITS-1:0]   i_anode,
  input  logic [7:0]              i_cathode,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_valid,
  output logic [NUM_DIGITS-1:0]   o_err,
  output logic                    o_upd,
  output logic [2:0]              o_upd_idx
);

  typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

  // Capture fires on the edge the counter steps from CntLast to STABLE_CYCLES-1.
  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 2);

  state_e                  r_state, w_state_nxt;
  logic [7:0]              r_cnt, w_cnt_nxt;
  logic [NUM_DIGITS-1:0]   r_s_an;
  logic [7:0]              r_s_ca;
  logic                    r_chg;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid, r_err;
  logic                    r_upd;
  logic [2:0]              r_upd_idx;

  logic                    w_an_ok, w_dec_ok, w_cap;
  logic [3:0]              w_nib;
  logic [2:0]              w_idx;

  assign w_an_ok = $onehot(~r_s_an);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_s_an[i]) w_idx = 3'(i);
    end
  end

  // dp (bit 7) is ignored by the decoder.
  always_comb begin
    w_dec_ok = 1'b1;
    w_nib    = 4'h0;
    case (r_s_ca[6:0])
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: w_dec_ok = 1'b0;
    endcase
  end

  // r_chg flags that the current sample differs from the one before it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    unique case (r_state)
      StWait: begin
        w_cnt_nxt = '0;
        if (w_an_ok) w_state_nxt = StSettle;
      end
      StSettle: begin
        if (!w_an_ok) begin
          w_state_nxt = StWait;
          w_cnt_nxt   = '0;
        end else if (r_chg) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == CntLast) begin
            w_cap       = 1'b1;
            w_state_nxt = StHeld;
          end
        end
      end
      StHeld: begin
        if (r_chg) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_an_ok ? StSettle : StWait;
        end
      end
      default: begin
        w_state_nxt = StWait;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= StWait;
      r_cnt     <= '0;
      r_s_an    <= '1;
      r_s_ca    <= '1;
      r_chg     <= 1'b0;
      r_digits  <= '0;
      r_valid   <= '0;
      r_err     <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
    end else begin
      r_s_an  <= i_anode;
      r_s_ca  <= i_cathode;
      r_chg   <= (i_anode != r_s_an) || (i_cathode != r_s_ca);
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_upd   <= w_cap;
      if (w_cap) begin
        r_upd_idx <= w_idx;
        if (w_dec_ok) begin
          r_digits[4*w_idx +: 4] <= w_nib;
          r_valid[w_idx]         <= 1'b1;
          r_err[w_idx]           <= 1'b0;
        end else begin
          r_valid[w_idx] <= 1'b0;
          r_err[w_idx]   <= 1'b1;
        end
      end
    end
  end

  assign o_digits  = r_digits;
  assign o_valid   = r_valid;
  assign o_err     = r_err;
  assign o_upd     = r_upd;
  assign o_upd_idx = r_upd_idx;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scan loop, latency, glitch, bad pattern,
// invalid anodes, mid-settle reset and dp masking, all against hand-computed values.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic [31:0] digits;
  logic [7:0]  valid;
  logic [7:0]  err;
  logic        upd;
  logic [2:0]  upd_idx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned upd_cnt;
  logic [2:0]  last_idx;
  logic        slot0_bad;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .STABLE_CYCLES(4),
    .NUM_DIGITS   (8)
  ) u_dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_anode  (anode),
    .i_cathode(cathode),
    .o_digits (digits),
    .o_valid  (valid),
    .o_err    (err),
    .o_upd    (upd),
    .o_upd_idx(upd_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Runs n cycles, tallying upd pulses and watching for slot 0 decaying to 0.
  task automatic run(input int n);
    upd_cnt   = 0;
    slot0_bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (upd) begin
        upd_cnt++;
        last_idx = upd_idx;
      end
      if (digits[3:0] == 4'h0) slot0_bad = 1'b1;
    end
  endtask

  logic [7:0] scan_an [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
  logic [7:0] scan_ca [4] = '{8'hA4, 8'h92, 8'h99, 8'h80};

  initial begin
    reset    = 1'b0;
    anode    = 8'hFF;
    cathode  = 8'hFF;
    last_idx = '0;
    step(2);
    check_eq("rst_digits", digits, 32'h0);
    check_eq("rst_valid", {24'h0, valid}, 32'h0);
    check_eq("rst_err", {24'h0, err}, 32'h0);
    check_eq("rst_upd", {29'h0, upd_idx, upd}, 32'h0);
    reset = 1'b1;
    step(1);

    // Scan loop
    for (int loop = 0; loop < 2; loop++) begin
      for (int d = 0; d < 4; d++) begin
        anode   = scan_an[d];
        cathode = scan_ca[d];
        run(100);
        check_eq($sformatf("scan_upd_cnt_%0d_%0d", loop, d), upd_cnt, 32'd1);
        check_eq($sformatf("scan_idx_%0d_%0d", loop, d), {29'h0, last_idx}, d);
      end
    end
    check_eq("scan_digits", digits, 32'h0000_8452);
    check_eq("scan_valid", {24'h0, valid}, 32'h0F);
    check_eq("scan_err", {24'h0, err}, 32'h0);

    // Latency: capture on edge 5, not edge 4
    anode   = 8'hFE;
    cathode = 8'hF9;
    step(4);
    check_eq("lat_upd_e4", {31'h0, upd}, 32'h0);
    step(1);
    check_eq("lat_upd_e5", {31'h0, upd}, 32'h1);
    check_eq("lat_slot0", {28'h0, digits[3:0]}, 32'h1);
    step(10);

    // Glitch of 3 cycles, then the held value is re-captured once
    cathode = 8'hC0;
    step(3);
    cathode = 8'hF9;
    run(20);
    check_eq("glitch_no_zero", {31'h0, slot0_bad}, 32'h0);
    check_eq("glitch_upd_cnt", upd_cnt, 32'd1);
    check_eq("glitch_slot0", {28'h0, digits[3:0]}, 32'h1);

    // Undecodable pattern on slot 4, then a good one
    anode   = 8'hEF;
    cathode = 8'hFF;
    run(10);
    check_eq("bad_upd_cnt", upd_cnt, 32'd1);
    check_eq("bad_idx", {29'h0, last_idx}, 32'd4);
    check_eq("bad_err4", {31'h0, err[4]}, 32'h1);
    check_eq("bad_valid4", {31'h0, valid[4]}, 32'h0);
    check_eq("bad_slot4", {28'h0, digits[19:16]}, 32'h0);
    cathode = 8'h8E;
    run(10);
    check_eq("good_slot4", {28'h0, digits[19:16]}, 32'hF);
    check_eq("good_valid4", {31'h0, valid[4]}, 32'h1);
    check_eq("good_err4", {31'h0, err[4]}, 32'h0);

    // Invalid anodes: two low, then blank
    anode   = 8'hFC;
    cathode = 8'hA4;
    run(50);
    check_eq("multi_upd_cnt", upd_cnt, 32'd0);
    anode = 8'hFF;
    run(50);
    check_eq("blank_upd_cnt", upd_cnt, 32'd0);
    check_eq("inv_digits", digits, 32'h000F_8451);
    check_eq("inv_valid", {24'h0, valid}, 32'h1F);
    check_eq("inv_err", {24'h0, err}, 32'h0);

    // dp on with 8 pattern decodes to 8
    anode   = 8'h7F;
    cathode = 8'h00;
    run(10);
    check_eq("dp_slot7", {28'h0, digits[31:28]}, 32'h8);
    check_eq("dp_valid", {24'h0, valid}, 32'h9F);
    check_eq("dp_idx", {29'h0, last_idx}, 32'd7);

    // Reset on edge 3 of a settle, then capture 5 edges after release
    anode   = 8'hFE;
    cathode = 8'hB0;
    step(2);
    reset = 1'b0;
    step(1);
    check_eq("mid_rst_digits", digits, 32'h0);
    check_eq("mid_rst_flags", {16'h0, valid, err}, 32'h0);
    check_eq("mid_rst_upd", {29'h0, upd_idx, upd}, 32'h0);
    reset = 1'b1;
    step(4);
    check_eq("post_rst_e4", {31'h0, upd}, 32'h0);
    step(1);
    check_eq("post_rst_e5", {31'h0, upd}, 32'h1);
    check_eq("post_rst_digits", digits, 32'h3);
    check_eq("post_rst_valid", {24'h0, valid}, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
